// File: rtl/serial_negate_pkg.sv
// Shared types for the multi-channel bit-serial negate/invert unit.
package serial_negate_pkg;

  // Per-word operation; the reserved encoding behaves as pass-through.
  typedef enum logic [1:0] {
    SN_PASS   = 2'b00,
    SN_NEGATE = 2'b01,
    SN_INVERT = 2'b10,
    SN_RSVD   = 2'b11
  } sn_mode_e;

  // Per-lane two's-complement state: copy bits until the first 1, then invert.
  typedef enum logic {
    SN_COPY = 1'b0,
    SN_INV  = 1'b1
  } sn_state_e;

  // Output bit of one lane for a given mode, effective state and input bit.
  function automatic logic sn_lane_out(sn_mode_e m, sn_state_e s, logic x);
    logic z;
    case (m)
      SN_NEGATE: z = (s == SN_COPY) ? x : ~x;
      SN_INVERT: z = ~x;
      default:   z = x;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/serial_negate_lane.sv
// One serial lane: combinational output/overflow plus its negate state bit.
module serial_negate_lane
  import serial_negate_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_en,
  input  logic     i_first,
  input  logic     i_last,
  input  sn_mode_e i_mode,
  input  logic     i_x,
  output logic     o_z,
  output logic     o_ovf_c
);

  sn_state_e r_state;
  sn_state_e w_state_eff;
  sn_state_e w_state_nxt;

  // The first bit of a word always starts from COPY, whatever the old word left.
  always_comb begin
    w_state_eff = i_first ? SN_COPY : r_state;
    w_state_nxt = w_state_eff;
    o_ovf_c     = 1'b0;
    o_z         = sn_lane_out(i_mode, w_state_eff, i_x);
    if (i_mode == SN_NEGATE) begin
      if (w_state_eff == SN_COPY && i_x) w_state_nxt = SN_INV;
      // Still copying at the MSB with a 1 means the word was -2^(W-1).
      o_ovf_c = i_last && (w_state_eff == SN_COPY) && i_x;
    end
  end

  // State advances only on valid bits; pass/invert words leave it untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= SN_COPY;
    else if (i_en && i_mode == SN_NEGATE)
      r_state <= w_state_nxt;
  end

endmodule

// File: rtl/serial_negate_mc.sv
// Multi-channel word-framed bit-serial pass/negate/invert with shared framing.
module serial_negate_mc
  import serial_negate_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int WORD_W = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_in_valid,
  input  logic [N_CH-1:0] i_in_bit,
  input  logic [1:0]      i_mode,
  output logic            o_out_valid,
  output logic [N_CH-1:0] o_out_bit,
  output logic            o_out_last,
  output logic [N_CH-1:0] o_ovf
);

  localparam int              CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  logic [CNT_W-1:0] r_cnt;
  sn_mode_e         r_mode_q;
  logic             r_out_valid;
  logic [N_CH-1:0]  r_out_bit;
  logic             r_out_last;
  logic [N_CH-1:0]  r_ovf;

  logic             w_first;
  logic             w_last;
  sn_mode_e         w_mode_eff;
  logic [N_CH-1:0]  w_z;
  logic [N_CH-1:0]  w_ovf;

  // Bit 0 uses the live mode so back-to-back words need no gap cycle.
  always_comb begin
    w_first    = (r_cnt == '0);
    w_last     = (r_cnt == CNT_LAST);
    w_mode_eff = w_first ? sn_mode_e'(i_mode) : r_mode_q;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    serial_negate_lane u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_in_valid),
      .i_first (w_first),
      .i_last  (w_last),
      .i_mode  (w_mode_eff),
      .i_x     (i_in_bit[g]),
      .o_z     (w_z[g]),
      .o_ovf_c (w_ovf[g])
    );
  end

  // Framing counter and mode latch; both freeze while the input stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_mode_q <= SN_PASS;
    end else if (i_in_valid) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      if (w_first) r_mode_q <= sn_mode_e'(i_mode);
    end
  end

  // Output registers: valid tracks the input every cycle, the rest hold on stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_bit   <= '0;
      r_out_last  <= 1'b0;
      r_ovf       <= '0;
    end else begin
      r_out_valid <= i_in_valid;
      if (i_in_valid) begin
        r_out_bit  <= w_z;
        r_out_last <= w_last;
        r_ovf      <= w_ovf;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_bit   = r_out_bit;
  assign o_out_last  = r_out_last;
  assign o_ovf       = r_ovf;

endmodule
